// File: rtl/usb4_lane_block_encoder.sv
// Per-lane USB4 TX block encoder: gathers lane bytes into 66b (Gen2) / 132b (Gen3) blocks
// or passes single bytes (Gen4), with a valid/ready handshake and a one-block output register.
module usb4_lane_block_encoder #(
  parameter int unsigned NUM_LANES      = 2,
  parameter logic [3:0]  TRANSPORT_DSEL = 4'd8,
  parameter logic [3:0]  IDLE_DSEL      = 4'd9
) (
  input  logic                       enc_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 gen_speed,
  input  logic [3:0]                 d_sel,
  input  logic [8*NUM_LANES-1:0]     lane_tx_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [132*NUM_LANES-1:0]   lane_tx_enc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       enable_ser,
  output logic                       new_sym
);

  localparam int unsigned BLK_W     = 132;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned MAX_BYTES = 16;
  localparam logic [1:0]  GEN4      = 2'd0;
  localparam logic [1:0]  GEN3      = 2'd1;
  localparam logic [1:0]  GEN2      = 2'd2;
  localparam logic [1:0]  GEN_RSVD  = 2'd3;

  logic [3:0]                              byte_cnt_q, byte_cnt_d;
  logic [1:0]                              gen_q, gen_d;
  logic                                    transport_q, transport_d;
  logic [NUM_LANES-1:0][MAX_BYTES-1:0][7:0] gath_q, gath_d;
  logic [NUM_LANES*BLK_W-1:0]              enc_q, enc_d;
  logic                                    out_valid_q, out_valid_d;
  logic                                    enable_ser_q, enable_ser_d;
  logic                                    new_sym_q, new_sym_d;

  logic [3:0]                              cnt_eff, last_idx, hdr;
  logic [2:0]                              hdr_w;
  logic                                    accept, idle_drop, last_byte, transport_c;
  logic [NUM_LANES-1:0][DATA_W-1:0]        data_c;
  logic [NUM_LANES*BLK_W-1:0]              blk_c;

  // A gen_speed change since the last cycle abandons any partial block.
  always_comb begin
    case (gen_speed)
      GEN3:    begin last_idx = 4'd15; hdr_w = 3'd4; hdr = transport_q ? 4'b1010 : 4'b0101; end
      GEN2:    begin last_idx = 4'd7;  hdr_w = 3'd2; hdr = transport_q ? 4'b0010 : 4'b0001; end
      default: begin last_idx = 4'd0;  hdr_w = 3'd0; hdr = 4'b0000; end
    endcase
    cnt_eff     = (gen_speed == gen_q) ? byte_cnt_q : 4'd0;
    in_ready    = rst & enable & (gen_speed != GEN_RSVD) &
                  ((cnt_eff != last_idx) | ~out_valid_q | out_ready);
    accept      = in_valid & in_ready;
    idle_drop   = (cnt_eff == 4'd0) & (d_sel == IDLE_DSEL);
    last_byte   = (cnt_eff == last_idx);
    transport_c = (cnt_eff == 4'd0) ? (d_sel == TRANSPORT_DSEL) : transport_q;
  end

  // Assemble {byte N-1 .. byte 0, header} per lane; the incoming byte is the last one.
  always_comb begin
    data_c = '0;
    blk_c  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (4'(k) < last_idx)
          data_c[l][8*k +: 8] = gath_q[l][k];
        else if (4'(k) == last_idx)
          data_c[l][8*k +: 8] = lane_tx_in[8*l +: 8];
      end
      blk_c[BLK_W*l +: BLK_W] = ({4'b0000, data_c[l]} << hdr_w) | BLK_W'(hdr);
    end
  end

  always_comb begin
    byte_cnt_d   = cnt_eff;
    gen_d        = gen_speed;
    transport_d  = transport_q;
    gath_d       = gath_q;
    enc_d        = enc_q;
    out_valid_d  = out_valid_q & ~out_ready;
    enable_ser_d = enable_ser_q;
    new_sym_d    = 1'b0;
    if (!enable) begin
      byte_cnt_d   = 4'd0;
      transport_d  = 1'b0;
      gath_d       = '0;
      enc_d        = '0;
      out_valid_d  = 1'b0;
      enable_ser_d = 1'b0;
    end else if (accept && !idle_drop) begin
      if (last_byte) begin
        byte_cnt_d   = 4'd0;
        enc_d        = blk_c;
        out_valid_d  = 1'b1;
        new_sym_d    = 1'b1;
        enable_ser_d = 1'b1;
      end else begin
        byte_cnt_d  = 4'(cnt_eff + 4'd1);
        transport_d = transport_c;
        for (int l = 0; l < NUM_LANES; l++)
          gath_d[l][cnt_eff] = lane_tx_in[8*l +: 8];
      end
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q   <= 4'd0;
      gen_q        <= GEN4;
      transport_q  <= 1'b0;
      gath_q       <= '0;
      enc_q        <= '0;
      out_valid_q  <= 1'b0;
      enable_ser_q <= 1'b0;
      new_sym_q    <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      gen_q        <= gen_d;
      transport_q  <= transport_d;
      gath_q       <= gath_d;
      enc_q        <= enc_d;
      out_valid_q  <= out_valid_d;
      enable_ser_q <= enable_ser_d;
      new_sym_q    <= new_sym_d;
    end
  end

  assign lane_tx_enc = enc_q;
  assign out_valid   = out_valid_q;
  assign enable_ser  = enable_ser_q;
  assign new_sym     = new_sym_q;

endmodule

// File: tb/tb_usb4_lane_block_encoder.sv
// Randomised + directed bench for usb4_lane_block_encoder against a queue-based block model.
module tb_usb4_lane_block_encoder;

  localparam int unsigned NL = 2;
  localparam int unsigned BW = 132 * NL;
  localparam logic [3:0]  TR = 4'd8;
  localparam logic [3:0]  ID = 4'd9;

  logic            enc_clk = 1'b0;
  logic            rst, enable, in_valid, in_ready, out_valid, out_ready, enable_ser, new_sym;
  logic [1:0]      gen_speed;
  logic [3:0]      d_sel;
  logic [8*NL-1:0] lane_tx_in;
  logic [BW-1:0]   lane_tx_enc;

  int n_tot = 0;
  int n_pass = 0;
  int stall_left = 0;
  bit rand_ordy = 1'b0;

  logic          pin_en = 1'b0;
  string         pin_name = "";
  logic [BW-1:0] pin_exp = '0;
  logic [BW-1:0] pin_msk = '0;

  // Model: bytes collected so far per lane, and the expected output register.
  logic [7:0]    mq [NL][$];
  logic [BW-1:0] m_enc;
  logic          m_ov, m_ns, m_es, m_tr;
  logic [1:0]    m_gen;

  usb4_lane_block_encoder #(.NUM_LANES(NL), .TRANSPORT_DSEL(TR), .IDLE_DSEL(ID)) dut (
    .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed), .d_sel(d_sel),
    .lane_tx_in(lane_tx_in), .in_valid(in_valid), .in_ready(in_ready),
    .lane_tx_enc(lane_tx_enc), .out_valid(out_valid), .out_ready(out_ready),
    .enable_ser(enable_ser), .new_sym(new_sym)
  );

  always #5 enc_clk = ~enc_clk;

  function automatic int blk_len(input logic [1:0] g);
    case (g)
      2'd0:    return 1;
      2'd1:    return 16;
      2'd2:    return 8;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic m_clear();
    for (int l = 0; l < NL; l++) mq[l].delete();
    m_enc = '0; m_ov = 1'b0; m_ns = 1'b0; m_es = 1'b0; m_tr = 1'b0;
  endtask

  // Compare on the falling edge, then advance the model with the inputs seen by the next rising edge.
  always @(negedge enc_clk) begin
    int n, cnt, hw;
    logic exp_rdy;
    logic [3:0] hdr;
    logic [131:0] lb;
    if (!rst) m_clear();
    else if (gen_speed != m_gen) for (int l = 0; l < NL; l++) mq[l].delete();
    m_gen   = gen_speed;
    n       = blk_len(gen_speed);
    cnt     = mq[0].size();
    exp_rdy = rst && enable && gen_speed != 2'd3 && (cnt != n - 1 || !m_ov || out_ready);

    chk("in_ready",    BW'(in_ready),   BW'(exp_rdy));
    chk("out_valid",   BW'(out_valid),  BW'(m_ov));
    chk("new_sym",     BW'(new_sym),    BW'(m_ns));
    chk("enable_ser",  BW'(enable_ser), BW'(m_es));
    chk("lane_tx_enc", lane_tx_enc,     m_enc);
    if (pin_en) chk(pin_name, lane_tx_enc & pin_msk, pin_exp);

    if (rst && !enable) m_clear();
    else if (rst) begin
      m_ns = 1'b0;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (in_valid && exp_rdy && !(cnt == 0 && d_sel == ID)) begin
        if (cnt == 0) m_tr = (d_sel == TR);
        for (int l = 0; l < NL; l++) mq[l].push_back(lane_tx_in[8*l +: 8]);
        if (mq[0].size() == n) begin
          hw  = (gen_speed == 2'd1) ? 4 : (gen_speed == 2'd2) ? 2 : 0;
          hdr = (gen_speed == 2'd1) ? (m_tr ? 4'b1010 : 4'b0101) :
                (gen_speed == 2'd2) ? (m_tr ? 4'b0010 : 4'b0001) : 4'b0000;
          for (int l = 0; l < NL; l++) begin
            lb = 132'(hdr);
            for (int k = 0; k < n; k++) lb = lb | (132'(mq[l][k]) << (hw + 8 * k));
            m_enc[132*l +: 132] = lb;
            mq[l].delete();
          end
          m_ov = 1'b1; m_ns = 1'b1; m_es = 1'b1;
        end
      end
    end
  end

  task automatic next_ordy(output logic o);
    if (stall_left > 0) begin o = 1'b0; stall_left--; end
    else if (rand_ordy) o = 1'($urandom_range(0, 1));
    else o = 1'b1;
  endtask

  task automatic cyc(input logic v, input logic [3:0] ds, input logic [8*NL-1:0] by, output logic acc);
    logic o;
    next_ordy(o);
    in_valid = v; d_sel = ds; lane_tx_in = by; out_ready = o;
    @(negedge enc_clk);
    acc = v & in_ready;
    @(posedge enc_clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] ds, input logic [8*NL-1:0] by);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      cyc(1'b1, ds, by, acc);
      guard++;
      if (!acc && guard > 200) begin
        $display("FAIL send_timeout: byte %h not accepted after %0d cycles", by, guard);
        $fatal(1, "input stalled");
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cyc(1'b0, 4'd0, 16'($urandom), acc);
  endtask

  task automatic pin(input string nm, input logic [BW-1:0] exp, input logic [BW-1:0] msk);
    pin_name = nm; pin_exp = exp; pin_msk = msk; pin_en = 1'b1;
  endtask

  localparam logic [BW-1:0] LANE0_MSK = {{132{1'b0}}, {132{1'b1}}};

  initial begin
    logic acc;
    logic [3:0] ds;
    rst = 1'b0; enable = 1'b0; gen_speed = 2'd0; d_sel = 4'd0;
    in_valid = 1'b0; out_ready = 1'b1; lane_tx_in = '0;
    repeat (3) @(posedge enc_clk);
    #1;
    rst = 1'b1; enable = 1'b1; gen_speed = 2'd1;

    // Gen3 transport block
    for (int k = 0; k < 16; k++) send(TR, {8'(8'hC0 + k), 8'(k)});
    pin("t1_gen3_block", {132'b0, 128'h0F0E0D0C0B0A09080706050403020100, 4'hA}, LANE0_MSK);
    idle(2);

    // Gen2 non-transport, both lanes
    gen_speed = 2'd2;
    for (int k = 0; k < 8; k++) send(4'd2, {8'(8'hB0 + k), 8'(8'hA0 + k)});
    pin("t2_gen2_lanes", {66'b0, 64'hB7B6B5B4B3B2B1B0, 2'b01, 66'b0, 64'hA7A6A5A4A3A2A1A0, 2'b01}, '1);
    idle(2);

    // Gen2 stream against a stalled serializer
    stall_left = 18;
    for (int k = 0; k < 16; k++) send(TR, {8'(8'h70 + k), 8'(8'h60 + k)});
    pin("t3_second_block", {66'b0, 64'h7F7E7D7C7B7A7978, 2'b10, 66'b0, 64'h6F6E6D6C6B6A6968, 2'b10}, '1);
    stall_left = 0;
    idle(2);

    // Gen3 with leading idles
    gen_speed = 2'd1;
    repeat (3) send(ID, 16'hEEEE);
    for (int k = 0; k < 16; k++) send(4'd1, {8'(8'h40 + k), 8'(8'h30 + k)});
    pin("t4_idle_drop", {128'h4F4E4D4C4B4A49484746454443424140, 4'h5,
                         128'h3F3E3D3C3B3A39383736353433323130, 4'h5}, '1);
    idle(1);

    // Partial block flushed by enable=0
    for (int k = 0; k < 5; k++) send(TR, {8'(8'h98 + k), 8'(8'h90 + k)});
    enable = 1'b0;
    idle(1);
    pin("t5_flush_zero", '0, '1);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) send(TR, {8'(8'h60 + k), 8'(8'h50 + k)});
    pin("t5_fresh_block", {132'b0, 128'h5F5E5D5C5B5A59585756555453525150, 4'hA}, LANE0_MSK);
    idle(1);

    // Gen4 byte pass-through
    gen_speed = 2'd0;
    send(TR, 16'h1111);
    pin("t6_byte_11", BW'(8'h11), BW'(8'hFF));
    send(TR, 16'h2222);
    pin("t6_byte_22", BW'(8'h22), BW'(8'hFF));
    idle(1);

    // Async reset mid-block
    gen_speed = 2'd1;
    for (int k = 0; k < 5; k++) send(TR, {8'(8'h35 + k), 8'(8'h25 + k)});
    rst = 1'b0;
    pin("reset_async_zero", '0, '1);
    idle(1);
    rst = 1'b1;
    idle(2);

    // Randomised traffic
    rand_ordy = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) gen_speed = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 3))
        0:       ds = TR;
        1:       ds = ID;
        default: ds = 4'($urandom);
      endcase
      cyc(($urandom_range(0, 9) < 7), ds, 16'($urandom), acc);
    end
    enable = 1'b1;
    rand_ordy = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
